// File: rtl/commitment_gen_param.sv
// Per-party commitment generator: walks every party of a round, issues one hash
// request per party over a req/ack handshake and collects digests into C.
module commitment_gen_param #(
    parameter int NUM_PARTIES = 16,
    parameter int SEED_W      = 128,
    parameter int DIGEST_W    = 256,
    parameter int AUX_W       = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            aux_en,
    input  logic [NUM_PARTIES*SEED_W-1:0]   seed,
    input  logic [AUX_W-1:0]                aux,
    input  logic [255:0]                    salt,
    input  logic [7:0]                      t,
    input  logic [7:0]                      j,
    output logic                            h_req,
    output logic [SEED_W-1:0]               h_seed,
    output logic [255:0]                    h_salt,
    output logic [7:0]                      h_t,
    output logic [7:0]                      h_j,
    output logic [7:0]                      h_party,
    output logic                            h_aux_valid,
    output logic [AUX_W-1:0]                h_aux,
    input  logic                            h_ack,
    input  logic [DIGEST_W-1:0]             h_digest,
    output logic                            c_wr,
    output logic [7:0]                      c_idx,
    output logic [NUM_PARTIES*DIGEST_W-1:0] C,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STORE,
        S_FIN
    } state_t;

    localparam logic [7:0] LAST = 8'(NUM_PARTIES - 1);

    state_t                          state;
    logic [7:0]                      p;
    logic [NUM_PARTIES*SEED_W-1:0]   seed_q;
    logic [AUX_W-1:0]                aux_q;
    logic                            aux_en_q;
    int                              slot;

    // Party 0 occupies the MSB slice of both the seed bus and C.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        slot        = 0;
        h_aux_valid = 1'b0;
        h_aux       = '0;
        slot        = NUM_PARTIES - 1 - int'(p);
        if (aux_en_q && (p == LAST) && ((state == S_REQ) || (state == S_WAIT))) begin
            h_aux_valid = 1'b1;
            h_aux       = aux_q;
        end
    end

    assign h_seed  = seed_q[slot*SEED_W +: SEED_W];
    assign h_party = p;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: C is observable after reset and must read zero, so this wide
            // register is reset explicitly rather than left as uninitialised storage.
            state    <= S_IDLE;
            p        <= '0;
            seed_q   <= '0;
            aux_q    <= '0;
            aux_en_q <= 1'b0;
            h_salt   <= '0;
            h_t      <= '0;
            h_j      <= '0;
            h_req    <= 1'b0;
            c_wr     <= 1'b0;
            c_idx    <= '0;
            C        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            c_wr <= 1'b0;
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q   <= seed;
                        aux_q    <= aux;
                        aux_en_q <= aux_en;
                        h_salt   <= salt;
                        h_t      <= t;
                        h_j      <= j;
                        p        <= '0;
                        busy     <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    h_req <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (h_ack) begin
                        C[slot*DIGEST_W +: DIGEST_W] <= h_digest;
                        h_req <= 1'b0;
                        c_wr  <= 1'b1;
                        c_idx <= p;
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (p == LAST) begin
                        state <= S_FIN;
                    end else begin
                        p     <= p + 8'd1;
                        state <= S_REQ;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
